// File: rtl/rdc_pulse_gen.sv
// Programmable per-core/per-event pulse-train transmitter whose outputs plug straight into the RDC events input.
// Define RDC_PGEN_JITTER_EN to add LFSR-driven gap jitter (0..3 extra low cycles per gap).
module rdc_pulse_gen #(
    parameter int N_CORES       = 4,
    parameter int CORE_EVENTS   = 2,
    parameter int WEIGHTS_WIDTH = 8,
    parameter int GAP_WIDTH     = 8,
    parameter int REPEAT_WIDTH  = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start_i,
    input  logic                     abort_i,
    input  logic [REPEAT_WIDTH-1:0]  repeat_i,
    input  logic [WEIGHTS_WIDTH-1:0] pulse_len_i [0:N_CORES-1][0:CORE_EVENTS-1],
    input  logic [GAP_WIDTH-1:0]     gap_len_i   [0:N_CORES-1][0:CORE_EVENTS-1],
    output logic [CORE_EVENTS-1:0]   events_o    [0:N_CORES-1],
    output logic                     busy_o,
    output logic                     done_o
);
    localparam int NCH = N_CORES * CORE_EVENTS;
    localparam int GCW = GAP_WIDTH + 2;

    typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW} state_t;

    state_t                   r_state     [NCH];
    state_t                   w_state_nxt [NCH];
    logic [WEIGHTS_WIDTH-1:0] r_hi_cnt    [NCH];
    logic [WEIGHTS_WIDTH-1:0] w_hi_nxt    [NCH];
    logic [GCW-1:0]           r_gap_cnt   [NCH];
    logic [GCW-1:0]           w_gap_nxt   [NCH];
    logic [REPEAT_WIDTH-1:0]  r_pls_cnt   [NCH];
    logic [REPEAT_WIDTH-1:0]  w_pls_nxt   [NCH];
    logic [WEIGHTS_WIDTH-1:0] r_sh_len    [NCH];
    logic [GAP_WIDTH-1:0]     r_sh_gap    [NCH];
    logic [REPEAT_WIDTH-1:0]  r_sh_rep;
    logic [CORE_EVENTS-1:0]   r_events    [0:N_CORES-1];
    logic                     r_busy;
    logic                     r_done;
    logic                     w_start_acc;
    logic                     w_any_nxt;
    logic [1:0]               w_jit;

    // A zero gap is stretched to one cycle so back-to-back pulses stay separated.
    function automatic logic [GCW-1:0] gap_load(input logic [GAP_WIDTH-1:0] gap,
                                                input logic [1:0] jit);
        logic [GCW-1:0] g;
        g = (gap == '0) ? GCW'(1) : GCW'(gap);
        return g + GCW'(jit);
    endfunction

`ifdef RDC_PGEN_JITTER_EN
    logic [15:0] r_lfsr;

    always_ff @(posedge clk_i) begin
        if (rst_i)
            r_lfsr <= 16'hACE1;
        else
            r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
    end

    assign w_jit = r_lfsr[1:0];
`else
    assign w_jit = 2'b00;
`endif

    always_comb begin
        w_start_acc = start_i & ~r_busy & ~abort_i;
        w_any_nxt   = 1'b0;
        for (int ch = 0; ch < NCH; ch++) begin
            w_state_nxt[ch] = r_state[ch];
            w_hi_nxt[ch]    = r_hi_cnt[ch];
            w_gap_nxt[ch]   = r_gap_cnt[ch];
            w_pls_nxt[ch]   = r_pls_cnt[ch];
            if (abort_i) begin
                w_state_nxt[ch] = S_IDLE;
            end else begin
                case (r_state[ch])
                    S_IDLE: begin
                        if (w_start_acc && pulse_len_i[ch / CORE_EVENTS][ch % CORE_EVENTS] != '0) begin
                            w_state_nxt[ch] = S_HIGH;
                            w_hi_nxt[ch]    = pulse_len_i[ch / CORE_EVENTS][ch % CORE_EVENTS];
                            w_pls_nxt[ch]   = repeat_i;
                        end
                    end
                    S_HIGH: begin
                        if (r_hi_cnt[ch] == WEIGHTS_WIDTH'(1)) begin
                            if (r_sh_rep != '0 && r_pls_cnt[ch] == REPEAT_WIDTH'(1)) begin
                                w_state_nxt[ch] = S_IDLE;
                            end else begin
                                w_state_nxt[ch] = S_LOW;
                                w_gap_nxt[ch]   = gap_load(r_sh_gap[ch], w_jit);
                                if (r_sh_rep != '0)
                                    w_pls_nxt[ch] = r_pls_cnt[ch] - REPEAT_WIDTH'(1);
                            end
                        end else begin
                            w_hi_nxt[ch] = r_hi_cnt[ch] - WEIGHTS_WIDTH'(1);
                        end
                    end
                    S_LOW: begin
                        if (r_gap_cnt[ch] == GCW'(1)) begin
                            w_state_nxt[ch] = S_HIGH;
                            w_hi_nxt[ch]    = r_sh_len[ch];
                        end else begin
                            w_gap_nxt[ch] = r_gap_cnt[ch] - GCW'(1);
                        end
                    end
                    default: w_state_nxt[ch] = S_IDLE;
                endcase
            end
            if (w_state_nxt[ch] != S_IDLE)
                w_any_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int ch = 0; ch < NCH; ch++) begin
                r_state[ch]  <= S_IDLE;
                r_sh_len[ch] <= '0;
                r_sh_gap[ch] <= '0;
            end
            for (int c = 0; c < N_CORES; c++)
                r_events[c] <= '0;
            r_sh_rep <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            for (int ch = 0; ch < NCH; ch++)
                r_state[ch] <= w_state_nxt[ch];
            if (w_start_acc) begin
                for (int ch = 0; ch < NCH; ch++) begin
                    r_sh_len[ch] <= pulse_len_i[ch / CORE_EVENTS][ch % CORE_EVENTS];
                    r_sh_gap[ch] <= gap_len_i[ch / CORE_EVENTS][ch % CORE_EVENTS];
                end
                r_sh_rep <= repeat_i;
            end
            for (int c = 0; c < N_CORES; c++)
                for (int e = 0; e < CORE_EVENTS; e++)
                    r_events[c][e] <= (w_state_nxt[c * CORE_EVENTS + e] == S_HIGH);
            r_busy <= w_any_nxt;
            // Strobe once when a run (or a start with every channel disabled) lands fully idle.
            r_done <= (r_busy | w_start_acc) & ~w_any_nxt;
        end
    end

    // Counters are only meaningful outside IDLE and are loaded on entry, so they carry no reset.
    always_ff @(posedge clk_i) begin
        for (int ch = 0; ch < NCH; ch++) begin
            r_hi_cnt[ch]  <= w_hi_nxt[ch];
            r_gap_cnt[ch] <= w_gap_nxt[ch];
            r_pls_cnt[ch] <= w_pls_nxt[ch];
        end
    end

    assign events_o = r_events;
    assign busy_o   = r_busy;
    assign done_o   = r_done;

endmodule

// File: tb/tb_rdc_pulse_gen.sv
// Scoreboard bench for rdc_pulse_gen: stimulus queues cycle-stamped expectations, a monitor pops and compares them.
module tb_rdc_pulse_gen;
    localparam int NC  = 4;
    localparam int CE  = 2;
    localparam int WW  = 8;
    localparam int GW  = 8;
    localparam int RW  = 8;
    localparam int NCH = NC * CE;

    logic          clk;
    logic          rst_i;
    logic          start_i;
    logic          abort_i;
    logic [RW-1:0] repeat_i;
    logic [WW-1:0] pulse_len_i [0:NC-1][0:CE-1];
    logic [GW-1:0] gap_len_i   [0:NC-1][0:CE-1];
    logic [CE-1:0] events_o    [0:NC-1];
    logic          busy_o;
    logic          done_o;

    typedef struct {
        int             cyc;
        logic [NCH-1:0] ev;
        logic           busy;
        logic           done;
        int             tid;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    rdc_pulse_gen #(
        .N_CORES(NC), .CORE_EVENTS(CE), .WEIGHTS_WIDTH(WW), .GAP_WIDTH(GW), .REPEAT_WIDTH(RW)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .abort_i(abort_i), .repeat_i(repeat_i),
        .pulse_len_i(pulse_len_i), .gap_len_i(gap_len_i), .events_o(events_o),
        .busy_o(busy_o), .done_o(done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin : monitor
        exp_t           x;
        logic [NCH-1:0] evf;
        for (int c = 0; c < NC; c++)
            for (int e = 0; e < CE; e++)
                evf[c * CE + e] = events_o[c][e];
        while (q.size() != 0 && q[0].cyc <= cyc) begin
            x = q.pop_front();
            checks++;
            if (x.cyc != cyc || evf !== x.ev || busy_o !== x.busy || done_o !== x.done) begin
                failures++;
                $display("FAIL t%0d cyc=%0d (want cyc %0d): got ev=%b busy=%b done=%b, required ev=%b busy=%b done=%b",
                         x.tid, cyc, x.cyc, evf, busy_o, done_o, x.ev, x.busy, x.done);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input int cy, input logic [NCH-1:0] ev, input logic b, input logic d, input int tid);
        exp_t x;
        x.cyc = cy; x.ev = ev; x.busy = b; x.done = d; x.tid = tid;
        q.push_back(x);
    endtask

    task automatic clr_cfg();
        for (int c = 0; c < NC; c++)
            for (int e = 0; e < CE; e++) begin
                pulse_len_i[c][e] = '0;
                gap_len_i[c][e]   = '0;
            end
    endtask

    // Config changes after an accepted start must have no effect.
    task automatic scramble();
        for (int c = 0; c < NC; c++)
            for (int e = 0; e < CE; e++) begin
                pulse_len_i[c][e] = 8'd9;
                gap_len_i[c][e]   = 8'd1;
            end
        repeat_i = 8'd3;
    endtask

    task automatic do_start();
        start_i = 1'b1;
        tick(1);
        start_i = 1'b0;
    endtask

    function automatic bit exp_bit(input int len, input int gap, input int rep, input int j);
        int g, per;
        if (len == 0) return 1'b0;
        g   = (gap == 0) ? 1 : gap;
        per = len + g;
        if (rep != 0 && (j / per) >= rep) return 1'b0;
        return (j % per) < len;
    endfunction

    // Hand-written H/L pattern for one channel, followed by the done strobe.
    task automatic run_pat(input int tid, input int ch, input string pat);
        int             k;
        logic [NCH-1:0] ev;
        k = cyc;
        for (int j = 0; j < pat.len(); j++) begin
            ev = '0;
            if (pat[j] == "H") ev[ch] = 1'b1;
            push(k + 1 + j, ev, 1'b1, 1'b0, tid);
        end
        push(k + 1 + pat.len(), '0, 1'b0, 1'b1, tid);
        push(k + 2 + pat.len(), '0, 1'b0, 1'b0, tid);
        do_start();
        scramble();
        tick(pat.len() + 2);
    endtask

    // Finite-repeat run of the current config, expectations from the closed-form pulse-train formula.
    task automatic run_cfg(input int tid, input int rep);
        int             k, L, tot, g;
        logic [NCH-1:0] ev;
        L = 0;
        for (int c = 0; c < NC; c++)
            for (int e = 0; e < CE; e++)
                if (pulse_len_i[c][e] != 0) begin
                    g   = (gap_len_i[c][e] == 0) ? 1 : int'(gap_len_i[c][e]);
                    tot = rep * int'(pulse_len_i[c][e]) + (rep - 1) * g;
                    if (tot > L) L = tot;
                end
        repeat_i = RW'(rep);
        k = cyc;
        for (int j = 0; j < L; j++) begin
            for (int c = 0; c < NC; c++)
                for (int e = 0; e < CE; e++)
                    ev[c * CE + e] = exp_bit(int'(pulse_len_i[c][e]), int'(gap_len_i[c][e]), rep, j);
            push(k + 1 + j, ev, 1'b1, 1'b0, tid);
        end
        push(k + 1 + L, '0, 1'b0, 1'b1, tid);
        push(k + 2 + L, '0, 1'b0, 1'b0, tid);
        do_start();
        scramble();
        tick(L + 2);
    endtask

    initial begin
        int             k;
        int             n;
        logic [NCH-1:0] ev;

        rst_i = 1'b1; start_i = 1'b0; abort_i = 1'b0; repeat_i = '0;
        clr_cfg();
        tick(2);
        k = cyc;
        push(k, '0, 1'b0, 1'b0, 1);
        push(k + 1, '0, 1'b0, 1'b0, 1);
        push(k + 2, '0, 1'b0, 1'b0, 1);
        rst_i = 1'b0;
        tick(3);

        // Single 5-cycle pulse on core 0 event 0.
        clr_cfg(); pulse_len_i[0][0] = 8'd5; repeat_i = 8'd1;
        run_pat(2, 0, "HHHHH");

        // Three 3-cycle pulses with 2-cycle gaps on core 1 event 1.
        clr_cfg(); pulse_len_i[1][1] = 8'd3; gap_len_i[1][1] = 8'd2; repeat_i = 8'd3;
        run_pat(3, 3, "HHHLLHHHLLHHH");

        // Zero gap is stretched to one cycle.
        clr_cfg(); pulse_len_i[2][0] = 8'd2; gap_len_i[2][0] = 8'd0; repeat_i = 8'd2;
        run_pat(4, 4, "HHLHH");

        // Every channel disabled: done next cycle, busy never rises.
        clr_cfg();
        run_cfg(5, 1);

        // Independent unaligned channels.
        clr_cfg();
        pulse_len_i[0][0] = 8'd2; gap_len_i[0][0] = 8'd1;
        pulse_len_i[2][1] = 8'd3; gap_len_i[2][1] = 8'd3;
        pulse_len_i[1][0] = 8'd1; gap_len_i[1][0] = 8'd5;
        run_cfg(6, 2);

        // Continuous run, ignored mid-run start, then abort.
        clr_cfg(); pulse_len_i[3][1] = 8'd4; gap_len_i[3][1] = 8'd4; repeat_i = 8'd0;
        n = 1010;
        k = cyc;
        for (int j = 0; j < n; j++) begin
            ev = '0;
            ev[7] = exp_bit(4, 4, 0, j);
            push(k + 1 + j, ev, 1'b1, 1'b0, 7);
        end
        push(k + 1 + n, '0, 1'b0, 1'b1, 7);
        push(k + 2 + n, '0, 1'b0, 1'b0, 7);
        do_start();
        while (cyc < k + 500) tick(1);
        pulse_len_i[0][0] = 8'd1; pulse_len_i[3][1] = 8'd1; repeat_i = 8'd1;
        do_start();
        while (cyc < k + n) tick(1);
        abort_i = 1'b1;
        tick(1);
        abort_i = 1'b0;
        tick(2);

        // Abort while idle gives no done; abort with start discards the start.
        clr_cfg(); pulse_len_i[0][0] = 8'd3; repeat_i = 8'd1;
        k = cyc;
        for (int j = 1; j <= 6; j++) push(k + j, '0, 1'b0, 1'b0, 8);
        abort_i = 1'b1;
        tick(1);
        start_i = 1'b1;
        tick(1);
        start_i = 1'b0; abort_i = 1'b0;
        tick(5);

        // Reset in the middle of a pulse, then a clean rerun.
        clr_cfg(); pulse_len_i[0][0] = 8'd5; repeat_i = 8'd1;
        k = cyc;
        push(k + 1, 8'h01, 1'b1, 1'b0, 9);
        push(k + 2, 8'h01, 1'b1, 1'b0, 9);
        push(k + 3, '0, 1'b0, 1'b0, 9);
        push(k + 4, '0, 1'b0, 1'b0, 9);
        do_start();
        tick(1);
        rst_i = 1'b1;
        tick(1);
        rst_i = 1'b0;
        tick(1);
        clr_cfg(); pulse_len_i[0][0] = 8'd5; repeat_i = 8'd1;
        run_pat(10, 0, "HHHHH");

        // Maximum pulse width and gap.
        clr_cfg(); pulse_len_i[0][1] = 8'd255; gap_len_i[0][1] = 8'd255;
        run_cfg(11, 2);

        // Maximum finite repeat count.
        clr_cfg(); pulse_len_i[1][0] = 8'd1; gap_len_i[1][0] = 8'd0;
        run_cfg(12, 255);

        for (int i = 0; i < 50 && q.size() != 0; i++) tick(1);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: pending=%0d required=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
